pwm_event_qualifier: RTL and testbench
======================================

Name: pwm_event_qualifier

Overview:
- Upstream stage of the timing manager: watches the triangular PWM carrier counter and emits a one-cycle `event_qualifier` pulse on the selected carrier peaks and/or valleys.
- The timing manager counts these pulses against its user ratio and uses them to align manual triggers.
- The block tracks carrier direction with a small FSM, applies a programmable holdoff, and flags malformed carrier values.

Parameters:
- CW, 16, carrier counter width.
- HW, 16, holdoff counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- carrier  in  CW  live PWM carrier count, triangular 0..carrier_max, synchronous to clk.
- carrier_max  in  CW  carrier peak value (from AXI register).
- qual_mode  in  2  00 none, 01 peak only, 10 valley only, 11 peak and valley.
- enable  in  1  gates pulse generation; the FSM always tracks.
- holdoff  in  HW  clk cycles to suppress further events after an emitted pulse.
- clear_err  in  1  clears `range_err`.
- event_qualifier  out  1  registered one-cycle pulse per qualified event.
- carrier_dir  out  1  1 = counting up, 0 = down or unknown.
- range_err  out  1  sticky: carrier exceeded carrier_max.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - event_qualifier = 0, carrier_dir = 0, range_err = 0.
  - lockout counter = 0.
  - Stats counters = 0.
- FSM states: IDLE, UP, DOWN. Transitions are evaluated on the sampled `carrier` each clk.
  - IDLE: carrier==0 → UP; carrier==carrier_max → DOWN; otherwise stay. No events are generated from IDLE.
  - UP: carrier==carrier_max → DOWN and raise peak_cand.
  - DOWN: carrier==0 → UP and raise valley_cand.
  - Any state: carrier>carrier_max → IDLE and set range_err. This has priority over all other transitions.
  - carrier_max==0: forced to IDLE every cycle; no events, no range_err unless carrier>0.
- carrier_dir = (state==UP).
- Candidate qualification:
  - cand = (peak_cand & qual_mode[0]) | (valley_cand & qual_mode[1]).
- Emit rule: event_qualifier <= cand & enable & (lockout==0).
  - Latency: exactly 1 clk after the cycle in which `carrier` presents the peak/valley value.
  - Pulse width is always 1 clk.
  - No two pulses on consecutive cycles when holdoff>0.
- Lockout counter:
  - Loads `holdoff` on the same edge that sets event_qualifier.
  - Otherwise decrements when nonzero and saturates at 0.
  - holdoff==0 means no suppression.
  - A candidate arriving on the cycle lockout reaches 0 from 1 is still suppressed; only lockout==0 at evaluation passes.
- enable low:
  - event_qualifier held 0.
  - Lockout forced to 0.
  - FSM continues tracking, so re-enabling mid-period yields the next correct edge without resynchronising.
- range_err:
  - Set has priority over clear_err when both occur in the same cycle.
  - Cleared only by clear_err or reset.
- Register change: carrier_max or qual_mode changing mid-period takes effect on the next sampled carrier. No event is synthesised retroactively.
- Reset mid-period: the FSM returns to IDLE, and the first event after reset is the second extremum seen. The first extremum only establishes direction.

Optional Feature:
- Macro: PWM_EVENT_QUALIFIER_STATS_EN.
- Defined: adds outputs `event_count` (32, emitted pulses) and `suppressed_count` (32, candidates blocked by lockout or enable low).
  - Both wrap at 2^32.
  - Both are cleared by reset and by clear_err.
- Not defined: these ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Shared package `pwm_event_qualifier_pkg` holds:
  - state enum (IDLE=2'd0, UP=2'd1, DOWN=2'd2);
  - qual_mode encodings (QM_NONE, QM_PEAK, QM_VALLEY, QM_BOTH).
- One natural sub-module: `holdoff_counter` (load/decrement/saturate, outputs busy = count!=0).

Test Plan:
- carrier_max=10, carrier ramps 0→10→0 repeatedly, qual_mode=11, holdoff=0, enable=1 → after the first extremum, one pulse 1 clk after each carrier==10 and each carrier==0; carrier_dir toggles accordingly.
- Same ramp, qual_mode=01 → pulses only after carrier==10 (peaks), one per 20-cycle period. qual_mode=10 → only after valleys. qual_mode=00 → none.
- carrier_max=4, qual_mode=11, holdoff=6 → the valley 4 clk after a peak is suppressed; the next peak passes. With STATS_EN, suppressed_count increments by 1 per suppression.
- Inject carrier=12 with carrier_max=10 → FSM goes IDLE, range_err=1, no pulse. clear_err asserted on the same cycle as another carrier=12 → range_err stays 1.
- enable low across a peak, then high before the following valley → no pulse at the peak, pulse at the valley (FSM kept tracking).
- Assert rst_n low mid-ramp at carrier=5 (up) → all outputs 0. After release, the first extremum produces no pulse; the second does.

Source files
------------

// File: rtl/pwm_event_qualifier_pkg.sv
// Shared types for the PWM event qualifier: carrier-direction FSM states,
// qualification mode encodings and common widths.
package pwm_event_qualifier_pkg;

    localparam int unsigned CW_DEF = 16;
    localparam int unsigned HW_DEF = 16;
    localparam int unsigned STAT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        QM_NONE   = 2'd0,
        QM_PEAK   = 2'd1,
        QM_VALLEY = 2'd2,
        QM_BOTH   = 2'd3
    } qual_mode_e;

    // Bit 0 of the mode selects peaks, bit 1 selects valleys.
    function automatic logic mode_accepts(input logic [1:0] qm,
                                          input logic       peak,
                                          input logic       valley);
        return (peak & qm[0]) | (valley & qm[1]);
    endfunction

endpackage : pwm_event_qualifier_pkg

// File: rtl/pwm_event_qualifier_holdoff_counter.sv
// Post-event lockout counter: loads on an emitted pulse, counts down to zero,
// and is flushed while event generation is disabled.
module holdoff_counter #(
    parameter int unsigned HW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [HW-1:0] load_val,
    input  logic          flush,
    output logic          busy
);

    logic [HW-1:0] count_q, count_d;
    logic          busy_q,  busy_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (flush) begin
            count_d = '0;
        end else if (count_q != '0) begin
            count_d = count_q - HW'(1);
        end
        busy_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule : holdoff_counter

// File: rtl/pwm_event_qualifier.sv
// Emits a one-cycle pulse on selected triangular-carrier peaks/valleys.
// Optional PWM_EVENT_QUALIFIER_STATS_EN adds emitted/suppressed event counters.
module pwm_event_qualifier
    import pwm_event_qualifier_pkg::*;
#(
    parameter int unsigned CW = CW_DEF,
    parameter int unsigned HW = HW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] carrier,
    input  logic [CW-1:0] carrier_max,
    input  logic [1:0]    qual_mode,
    input  logic          enable,
    input  logic [HW-1:0] holdoff,
    input  logic          clear_err,
    output logic          event_qualifier,
    output logic          carrier_dir,
    output logic          range_err
`ifdef PWM_EVENT_QUALIFIER_STATS_EN
    ,
    output logic [STAT_W-1:0] event_count,
    output logic [STAT_W-1:0] suppressed_count
`endif
);

    state_e state_q, state_d;
    logic   event_qualifier_q, event_qualifier_d;
    logic   carrier_dir_q, carrier_dir_d;
    logic   range_err_q, range_err_d;

    logic   over_range;
    logic   peak_cand;
    logic   valley_cand;
    logic   cand;
    logic   emit;
    logic   suppress;
    logic   lock_busy;

    // Direction tracking; out-of-range carrier and a zero period force IDLE.
    always_comb begin
        state_d     = state_q;
        peak_cand   = 1'b0;
        valley_cand = 1'b0;
        over_range  = (carrier > carrier_max);

        if (over_range || (carrier_max == '0)) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (carrier == '0) begin
                        state_d = UP;
                    end else if (carrier == carrier_max) begin
                        state_d = DOWN;
                    end
                end
                UP: begin
                    if (carrier == carrier_max) begin
                        state_d   = DOWN;
                        peak_cand = 1'b1;
                    end
                end
                DOWN: begin
                    if (carrier == '0) begin
                        state_d     = UP;
                        valley_cand = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Qualification, emit decision and sticky error.
    always_comb begin
        cand              = mode_accepts(qual_mode, peak_cand, valley_cand);
        emit              = cand & enable & ~lock_busy;
        suppress          = cand & ~emit;
        event_qualifier_d = emit;
        carrier_dir_d     = (state_d == UP);
        range_err_d       = range_err_q;
        if (over_range) begin
            range_err_d = 1'b1;
        end else if (clear_err) begin
            range_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            event_qualifier_q <= 1'b0;
            carrier_dir_q     <= 1'b0;
            range_err_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            event_qualifier_q <= event_qualifier_d;
            carrier_dir_q     <= carrier_dir_d;
            range_err_q       <= range_err_d;
        end
    end

    holdoff_counter #(
        .HW (HW)
    ) u_holdoff (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (emit),
        .load_val (holdoff),
        .flush    (~enable),
        .busy     (lock_busy)
    );

    assign event_qualifier = event_qualifier_q;
    assign carrier_dir     = carrier_dir_q;
    assign range_err       = range_err_q;

`ifdef PWM_EVENT_QUALIFIER_STATS_EN
    logic [STAT_W-1:0] event_cnt_q, event_cnt_d;
    logic [STAT_W-1:0] supp_cnt_q,  supp_cnt_d;

    // Wrapping counters; clear_err resets them along with the error flag.
    always_comb begin
        event_cnt_d = event_cnt_q;
        supp_cnt_d  = supp_cnt_q;
        if (clear_err) begin
            event_cnt_d = '0;
            supp_cnt_d  = '0;
        end else begin
            if (emit) begin
                event_cnt_d = event_cnt_q + STAT_W'(1);
            end
            if (suppress) begin
                supp_cnt_d = supp_cnt_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_cnt_q <= '0;
            supp_cnt_q  <= '0;
        end else begin
            event_cnt_q <= event_cnt_d;
            supp_cnt_q  <= supp_cnt_d;
        end
    end

    assign event_count      = event_cnt_q;
    assign suppressed_count = supp_cnt_q;
`endif

endmodule : pwm_event_qualifier

// File: tb/tb_pwm_event_qualifier.sv
// Directed bench for pwm_event_qualifier: ramps, mode selection, holdoff
// boundaries, range error, enable gating and mid-period reset.
module tb_pwm_event_qualifier;
    import pwm_event_qualifier_pkg::*;

    localparam int unsigned CW = 16;
    localparam int unsigned HW = 16;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] carrier;
    logic [CW-1:0] carrier_max;
    logic [1:0]    qual_mode;
    logic          enable;
    logic [HW-1:0] holdoff;
    logic          clear_err;
    logic          event_qualifier;
    logic          carrier_dir;
    logic          range_err;
`ifdef PWM_EVENT_QUALIFIER_STATS_EN
    logic [31:0]   event_count;
    logic [31:0]   suppressed_count;
`endif

    int n_checks;
    int n_fail;
    int exp_events;
    int exp_supp;

    pwm_event_qualifier #(
        .CW (CW),
        .HW (HW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .carrier         (carrier),
        .carrier_max     (carrier_max),
        .qual_mode       (qual_mode),
        .enable          (enable),
        .holdoff         (holdoff),
        .clear_err       (clear_err),
        .event_qualifier (event_qualifier),
        .carrier_dir     (carrier_dir),
        .range_err       (range_err)
`ifdef PWM_EVENT_QUALIFIER_STATS_EN
        ,
        .event_count     (event_count),
        .suppressed_count(suppressed_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present one carrier sample; outputs are checked just after the edge.
    task automatic present(input int c, input logic ev, input logic dir);
        carrier = CW'(c);
        @(posedge clk);
        #1;
        check($sformatf("evt c=%0d", c), 32'(event_qualifier), 32'(ev));
        check($sformatf("dir c=%0d", c), 32'(carrier_dir), 32'(dir));
        if (ev) exp_events++;
    endtask

    // One carrier period starting just after a valley: 1..mx..0.
    task automatic period(input int mx, input logic pk, input logic vy);
        for (int c = 1; c < mx; c++) present(c, 1'b0, 1'b1);
        present(mx, pk, 1'b0);
        for (int c = mx - 1; c > 0; c--) present(c, 1'b0, 1'b0);
        present(0, vy, 1'b1);
    endtask

    task automatic check_stats(input string tag);
`ifdef PWM_EVENT_QUALIFIER_STATS_EN
        check({tag, " event_count"}, event_count, 32'(exp_events));
        check({tag, " suppressed_count"}, suppressed_count, 32'(exp_supp));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        exp_events  = 0;
        exp_supp    = 0;
        rst_n       = 1'b1;
        carrier     = '0;
        carrier_max = CW'(10);
        qual_mode   = QM_BOTH;
        enable      = 1'b1;
        holdoff     = '0;
        clear_err   = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("reset evt", 32'(event_qualifier), 32'd0);
        check("reset dir", 32'(carrier_dir), 32'd0);
        check("reset range_err", 32'(range_err), 32'd0);
        check_stats("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // First valley from IDLE only establishes direction.
        present(0, 1'b0, 1'b1);
        period(10, 1'b1, 1'b1);
        period(10, 1'b1, 1'b1);

        qual_mode = QM_PEAK;
        period(10, 1'b1, 1'b0);
        qual_mode = QM_VALLEY;
        period(10, 1'b0, 1'b1);
        qual_mode = QM_NONE;
        period(10, 1'b0, 1'b0);
        qual_mode = QM_BOTH;
        check_stats("modes");

        // Holdoff: valley 4 clk after a peak sits inside the lockout window.
        carrier_max = CW'(4);
        holdoff     = HW'(6);
        period(4, 1'b1, 1'b0); exp_supp++;
        period(4, 1'b1, 1'b0); exp_supp++;
        holdoff = HW'(4);
        period(4, 1'b1, 1'b0); exp_supp++;
        holdoff = HW'(3);
        period(4, 1'b1, 1'b1);
        holdoff = '0;
        check_stats("holdoff");

        // Range error: set, set-beats-clear, then clear.
        carrier_max = CW'(10);
        present(1, 1'b0, 1'b1);
        present(2, 1'b0, 1'b1);
        present(12, 1'b0, 1'b0);
        check("range_err set", 32'(range_err), 32'd1);
        clear_err = 1'b1;
        present(12, 1'b0, 1'b0);
        check("range_err set over clear", 32'(range_err), 32'd1);
        exp_events = 0;
        exp_supp   = 0;
        check_stats("clear_err");
        present(3, 1'b0, 1'b0);
        check("range_err cleared", 32'(range_err), 32'd0);
        clear_err = 1'b0;
        for (int c = 4; c < 10; c++) present(c, 1'b0, 1'b0);
        present(10, 1'b0, 1'b0);
        for (int c = 9; c > 0; c--) present(c, 1'b0, 1'b0);
        present(0, 1'b1, 1'b1);

        // Enable low across a peak; FSM keeps tracking for the valley.
        enable = 1'b0;
        for (int c = 1; c < 10; c++) present(c, 1'b0, 1'b1);
        present(10, 1'b0, 1'b0);
        exp_supp++;
        enable = 1'b1;
        for (int c = 9; c > 0; c--) present(c, 1'b0, 1'b0);
        present(0, 1'b1, 1'b1);
        check_stats("enable");

        // Reset mid-ramp on the way up.
        for (int c = 1; c <= 5; c++) present(c, 1'b0, 1'b1);
        rst_n   = 1'b0;
        carrier = CW'(6);
        #1;
        check("midreset evt", 32'(event_qualifier), 32'd0);
        check("midreset dir", 32'(carrier_dir), 32'd0);
        check("midreset range_err", 32'(range_err), 32'd0);
        exp_events = 0;
        exp_supp   = 0;
        check_stats("midreset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 7; c < 10; c++) present(c, 1'b0, 1'b0);
        present(10, 1'b0, 1'b0);
        for (int c = 9; c > 0; c--) present(c, 1'b0, 1'b0);
        present(0, 1'b1, 1'b1);
        check_stats("after reset");

        // Zero period: forced IDLE, error only when carrier is nonzero.
        carrier_max = '0;
        present(0, 1'b0, 1'b0);
        check("max0 no err", 32'(range_err), 32'd0);
        present(1, 1'b0, 1'b0);
        check("max0 err", 32'(range_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pwm_event_qualifier
